timekeeper_lap: RTL and testbench

- Next-generation clock/stopwatch core that runs entirely in the `clk` domain, using tick enables instead of gated or ripple clocks.
- Contains three parts:
  - a real-time clock with a synchronous time-set path;
  - an up/down stopwatch that saturates at zero when counting down;
  - a LAPS-deep lap-capture FIFO.
- A button-driven view FSM selects which time value drives the display outputs (clock, stopwatch or lap head).
- Sits between the board button/switch synchronisers and the 7-segment display decoder.

---
 rtl/timekeeper_lap_pkg.sv | 29 ++
 rtl/count_mod.sv | 36 +++
 rtl/timekeeper_lap.sv | 198 +++++++++++++++++++
 tb/tb_timekeeper_lap.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/timekeeper_lap_pkg.sv
// Shared constants, view encodings and lap-entry packing for the timekeeper_lap core.
package timekeeper_lap_pkg;

  localparam int CS_MAX = 99;
  localparam int SM_MAX = 59;

  localparam int CS_W = 7;
  localparam int SM_W = 6;
  localparam int H_W  = 5;

  // Lap entry layout: {h, m, s, cs}
  localparam int LAP_W  = 24;
  localparam int CS_OFF = 0;
  localparam int S_OFF  = 7;
  localparam int M_OFF  = 13;
  localparam int H_OFF  = 19;

  typedef enum logic [1:0] {
    VIEW_CLK = 2'd0,
    VIEW_CRO = 2'd1,
    VIEW_LAP = 2'd2
  } view_t;

  function automatic logic [LAP_W-1:0] pack_lap(input logic [H_W-1:0] h, input logic [SM_W-1:0] m,
                                                 input logic [SM_W-1:0] s, input logic [CS_W-1:0] cs);
    return {h, m, s, cs};
  endfunction

endpackage

// File: rtl/count_mod.sv
// Modulo-(MAX+1) up/down counter with clear/load and a same-cycle carry/borrow for cascading.
module count_mod
  import timekeeper_lap_pkg::*;
#(
  parameter int MAX   = 9,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             res,
  input  logic             en,
  input  logic             ud,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] ld_val,
  output logic [WIDTH-1:0] Count,
  output logic             carry
);

  localparam logic [WIDTH-1:0] LIMIT = WIDTH'(MAX);

  assign carry = en & (ud ? (Count == LIMIT) : (Count == '0));

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      Count <= '0;
    end else if (clr) begin
      Count <= '0;
    end else if (load) begin
      Count <= ld_val;
    end else if (en) begin
      if (ud) Count <= (Count == LIMIT) ? '0 : Count + 1'b1;
      else    Count <= (Count == '0) ? LIMIT : Count - 1'b1;
    end
  end

endmodule

// File: rtl/timekeeper_lap.sv
// Real-time clock, up/down stopwatch and lap FIFO sharing one tick prescaler,
// with a button-driven view selecting what reaches the display fields.
module timekeeper_lap
  import timekeeper_lap_pkg::*;
#(
  parameter int CLK_DIV  = 1,
  parameter int LAPS     = 4,
  parameter int HOUR_MAX = 23
) (
  input  logic                       clk,
  input  logic                       res,
  input  logic                       run,
  input  logic                       zera,
  input  logic                       ud,
  input  logic                       lap,
  input  logic                       lap_rd,
  input  logic                       rc,
  input  logic                       set_en,
  input  logic [4:0]                 set_h,
  input  logic [5:0]                 set_m,
  input  logic [5:0]                 set_s,
  output logic [6:0]                 centsegundos,
  output logic [5:0]                 segundos,
  output logic [5:0]                 minutos,
  output logic [4:0]                 hora,
  output logic [1:0]                 view,
  output logic                       nrc,
  output logic                       done,
  output logic [$clog2(LAPS+1)-1:0]  lap_count,
  output logic                       lap_full,
  output logic                       lap_empty
);

  localparam int PS_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PTR_W = $clog2(LAPS);
  localparam int CNT_W = $clog2(LAPS+1);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(CLK_DIV - 1);
  localparam logic [H_W-1:0]  H_LIM   = H_W'(HOUR_MAX);
  localparam logic [SM_W-1:0] SM_LIM  = SM_W'(SM_MAX);

  logic [PS_W-1:0] presc_reg;
  logic            tick;
  logic lap_prev_reg, lap_rd_prev_reg, rc_prev_reg, ud_prev_reg, done_reg;
  logic push_edge, pop_edge, rc_edge;

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      presc_reg       <= '0;
      lap_prev_reg    <= 1'b0;
      lap_rd_prev_reg <= 1'b0;
      rc_prev_reg     <= 1'b0;
      ud_prev_reg     <= 1'b0;
    end else begin
      presc_reg       <= (set_en || presc_reg == PS_LAST) ? '0 : presc_reg + 1'b1;
      lap_prev_reg    <= lap;
      lap_rd_prev_reg <= lap_rd;
      rc_prev_reg     <= rc;
      ud_prev_reg     <= ud;
    end
  end

  assign tick      = (presc_reg == PS_LAST);
  assign push_edge = lap & ~lap_prev_reg;
  assign pop_edge  = lap_rd & ~lap_rd_prev_reg;
  assign rc_edge   = rc & ~rc_prev_reg;

  logic [H_W-1:0]  sat_h;
  logic [SM_W-1:0] sat_m, sat_s;
  assign sat_h = (set_h > H_LIM)  ? H_LIM  : set_h;
  assign sat_m = (set_m > SM_LIM) ? SM_LIM : set_m;
  assign sat_s = (set_s > SM_LIM) ? SM_LIM : set_s;

  // Index 0 is the real-time clock, index 1 the stopwatch.
  logic [CS_W-1:0] cs_q [2];
  logic [SM_W-1:0] s_q  [2];
  logic [SM_W-1:0] m_q  [2];
  logic [H_W-1:0]  h_q  [2];
  logic [1:0] cnt_en, cnt_ud, cnt_clr, cnt_load;
  logic [1:0] c_cs, c_s, c_m, c_h;
  logic       unused_carry;

  logic sw_adv, sw_zero, sw_one, sw_en;
  assign sw_adv  = tick & run & zera;
  assign sw_zero = (h_q[1] == '0) && (m_q[1] == '0) && (s_q[1] == '0) && (cs_q[1] == '0);
  assign sw_one  = (h_q[1] == '0) && (m_q[1] == '0) && (s_q[1] == '0) && (cs_q[1] == CS_W'(1));
  // Down-count never leaves zero; it only flags done.
  assign sw_en   = sw_adv & ~(~ud & (sw_zero | done_reg));

  assign cnt_en   = {sw_en, tick & ~set_en};
  assign cnt_ud   = {ud, 1'b1};
  assign cnt_clr  = {~zera, 1'b0};
  assign cnt_load = {1'b0, set_en};
  assign unused_carry = c_h[0] ^ c_h[1];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chain
      count_mod #(.MAX(CS_MAX), .WIDTH(CS_W)) u_cs (
        .clk(clk), .res(res), .en(cnt_en[gi]), .ud(cnt_ud[gi]), .clr(cnt_clr[gi]),
        .load(cnt_load[gi]), .ld_val('0), .Count(cs_q[gi]), .carry(c_cs[gi]));
      count_mod #(.MAX(SM_MAX), .WIDTH(SM_W)) u_s (
        .clk(clk), .res(res), .en(c_cs[gi]), .ud(cnt_ud[gi]), .clr(cnt_clr[gi]),
        .load(cnt_load[gi]), .ld_val(gi == 0 ? sat_s : '0), .Count(s_q[gi]), .carry(c_s[gi]));
      count_mod #(.MAX(SM_MAX), .WIDTH(SM_W)) u_m (
        .clk(clk), .res(res), .en(c_s[gi]), .ud(cnt_ud[gi]), .clr(cnt_clr[gi]),
        .load(cnt_load[gi]), .ld_val(gi == 0 ? sat_m : '0), .Count(m_q[gi]), .carry(c_m[gi]));
      count_mod #(.MAX(HOUR_MAX), .WIDTH(H_W)) u_h (
        .clk(clk), .res(res), .en(c_m[gi]), .ud(cnt_ud[gi]), .clr(cnt_clr[gi]),
        .load(cnt_load[gi]), .ld_val(gi == 0 ? sat_h : '0), .Count(h_q[gi]), .carry(c_h[gi]));
    end
  endgenerate

  always_ff @(posedge clk or negedge res) begin
    if (!res)                       done_reg <= 1'b0;
    else if (!zera)                 done_reg <= 1'b0;
    else if (ud && !ud_prev_reg)    done_reg <= 1'b0;
    else if (sw_adv && !ud && (sw_zero || sw_one)) done_reg <= 1'b1;
  end

  logic [LAP_W-1:0] lap_mem [LAPS];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push, do_pop;
  logic [LAP_W-1:0] sw_pack, lap_head;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(LAPS - 1)) ? '0 : p + 1'b1;
  endfunction

  assign sw_pack   = pack_lap(h_q[1], m_q[1], s_q[1], cs_q[1]);
  assign lap_empty = (count_reg == '0);
  assign lap_full  = (count_reg == CNT_W'(LAPS));
  assign lap_count = count_reg;
  assign do_pop    = pop_edge & zera & ~lap_empty;
  assign do_push   = push_edge & zera & (~lap_full | do_pop);
  assign lap_head  = lap_empty ? '0 : lap_mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) lap_mem[wr_ptr_reg] <= sw_pack;
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res || !zera) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= bump(wr_ptr_reg);
      if (do_pop)  rd_ptr_reg <= bump(rd_ptr_reg);
      if (do_push && !do_pop)      count_reg <= count_reg + 1'b1;
      else if (do_pop && !do_push) count_reg <= count_reg - 1'b1;
    end
  end

  view_t view_reg, view_next;

  always_ff @(posedge clk or negedge res) begin
    if (!res) view_reg <= VIEW_CLK;
    else      view_reg <= view_next;
  end

  always_comb begin
    view_next = view_reg;
    case (view_reg)
      VIEW_CLK: if (rc_edge) view_next = VIEW_CRO;
      VIEW_CRO: if (rc_edge) view_next = VIEW_LAP;
      VIEW_LAP: if (rc_edge) view_next = VIEW_CLK;
      default:  view_next = VIEW_CLK;
    endcase
  end

  always_comb begin
    centsegundos = cs_q[0];
    segundos     = s_q[0];
    minutos      = m_q[0];
    hora         = h_q[0];
    case (view_reg)
      VIEW_CRO: begin
        centsegundos = cs_q[1];
        segundos     = s_q[1];
        minutos      = m_q[1];
        hora         = h_q[1];
      end
      VIEW_LAP: begin
        centsegundos = lap_head[CS_OFF +: CS_W];
        segundos     = lap_head[S_OFF +: SM_W];
        minutos      = lap_head[M_OFF +: SM_W];
        hora         = lap_head[H_OFF +: H_W];
      end
      default: ;
    endcase
  end

  assign view = view_reg;
  assign nrc  = (view_reg == VIEW_CLK);
  assign done = done_reg;

endmodule

// File: tb/tb_timekeeper_lap.sv
// Directed bench for timekeeper_lap: clock set/wrap, countdown saturation, lap FIFO, clear, view FSM, reset.
module tb_timekeeper_lap;

  logic clk = 1'b0;
  logic res, run, zera, ud, lap, lap_rd, rc, set_en;
  logic [4:0] set_h;
  logic [5:0] set_m, set_s;
  logic [6:0] centsegundos;
  logic [5:0] segundos, minutos;
  logic [4:0] hora;
  logic [1:0] view;
  logic       nrc, done, lap_full, lap_empty;
  logic [2:0] lap_count;

  int n_checks = 0;
  int n_fail   = 0;

  timekeeper_lap #(.CLK_DIV(1), .LAPS(4), .HOUR_MAX(23)) dut (
    .clk(clk), .res(res), .run(run), .zera(zera), .ud(ud), .lap(lap), .lap_rd(lap_rd),
    .rc(rc), .set_en(set_en), .set_h(set_h), .set_m(set_m), .set_s(set_s),
    .centsegundos(centsegundos), .segundos(segundos), .minutos(minutos), .hora(hora),
    .view(view), .nrc(nrc), .done(done), .lap_count(lap_count),
    .lap_full(lap_full), .lap_empty(lap_empty));

  always #5 clk = ~clk;

  wire [23:0] disp = {hora, minutos, segundos, centsegundos};

  function automatic logic [23:0] pk(input int h, input int m, input int s, input int cs);
    return {h[4:0], m[5:0], s[5:0], cs[6:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_rc();
    rc = 1'b1; step(1);
    rc = 1'b0; step(1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_disp"}, disp, 0);
    check({tag, "_view"}, view, 0);
    check({tag, "_nrc"}, nrc, 1);
    check({tag, "_done"}, done, 0);
    check({tag, "_cnt"}, lap_count, 0);
    check({tag, "_empty"}, lap_empty, 1);
    check({tag, "_full"}, lap_full, 0);
  endtask

  logic [23:0] pop_exp [5];
  int          view_exp [4];

  initial begin
    res = 1'b0; run = 1'b0; zera = 1'b1; ud = 1'b1; lap = 1'b0; lap_rd = 1'b0;
    rc = 1'b0; set_en = 1'b0; set_h = '0; set_m = '0; set_s = '0;
    #3;
    check_reset_state("rst");
    #9;
    res = 1'b1;

    // Clock set, saturation and wrap
    set_en = 1'b1; set_h = 5'd12; set_m = 6'd34; set_s = 6'd56;
    step(1);
    check("set_exact", disp, pk(12, 34, 56, 0));
    set_h = 5'd31; set_m = 6'd63; set_s = 6'd63;
    step(1);
    check("set_sat", disp, pk(23, 59, 59, 0));
    step(3);
    check("set_hold", disp, pk(23, 59, 59, 0));
    set_en = 1'b0;
    step(100);
    check("clk_wrap", disp, pk(0, 0, 0, 0));
    check("clk_nrc", nrc, 1);

    // Countdown saturation
    pulse_rc();
    check("view_cro", view, 1);
    check("nrc_cro", nrc, 0);
    zera = 1'b0; step(1);
    check("zera_done", done, 0);
    check("zera_sw", disp, 0);
    zera = 1'b1; run = 1'b1; ud = 1'b1;
    step(100);
    check("up_1s", disp, pk(0, 0, 1, 0));
    ud = 1'b0;
    step(100);
    check("down_zero", disp, 0);
    check("down_done", done, 1);
    step(50);
    check("sat_zero", disp, 0);
    check("sat_done", done, 1);
    ud = 1'b1;
    step(1);
    check("ud_up_done", done, 0);
    check("ud_up_resume", disp, pk(0, 0, 0, 1));
    run = 1'b0;
    zera = 1'b0; step(1);
    zera = 1'b1; ud = 1'b0; run = 1'b1;
    step(1);
    check("zero_start_sw", disp, 0);
    check("zero_start_done", done, 1);
    run = 1'b0; ud = 1'b1;
    step(1);
    check("zero_start_clr", done, 0);

    // Lap capture and order
    zera = 1'b0; step(1);
    zera = 1'b1; run = 1'b1;
    step(10);
    lap = 1'b1; step(1); lap = 1'b0; step(9);
    lap = 1'b1; step(1); lap = 1'b0; step(9);
    lap = 1'b1; step(1); lap = 1'b0;
    run = 1'b0;
    check("lap_cnt3", lap_count, 3);
    pulse_rc();
    check("view_lap", view, 2);
    check("lap_head1", disp, pk(0, 0, 0, 10));
    lap_rd = 1'b1; step(1); lap_rd = 1'b0; step(1);
    check("lap_head2", disp, pk(0, 0, 0, 20));
    check("lap_cnt2", lap_count, 2);

    // FIFO boundaries
    zera = 1'b0; step(1);
    zera = 1'b1; run = 1'b1; step(1);
    for (int i = 0; i < 5; i++) begin
      lap = 1'b1; step(1);
      lap = 1'b0; step(1);
    end
    run = 1'b0;
    check("fill_cnt", lap_count, 4);
    check("fill_full", lap_full, 1);
    check("fill_head", disp, pk(0, 0, 0, 1));
    lap = 1'b1; lap_rd = 1'b1; step(1);
    lap = 1'b0; lap_rd = 1'b0; step(1);
    check("full_pp_cnt", lap_count, 4);
    check("full_pp_head", disp, pk(0, 0, 0, 3));
    pop_exp[0] = pk(0, 0, 0, 5);
    pop_exp[1] = pk(0, 0, 0, 7);
    pop_exp[2] = pk(0, 0, 0, 11);
    pop_exp[3] = '0;
    pop_exp[4] = '0;
    for (int i = 0; i < 5; i++) begin
      lap_rd = 1'b1; step(1);
      lap_rd = 1'b0; step(1);
      check($sformatf("pop%0d", i), disp, pop_exp[i]);
    end
    check("drain_empty", lap_empty, 1);
    check("drain_full", lap_full, 0);
    check("drain_cnt", lap_count, 0);
    lap = 1'b1; lap_rd = 1'b1; step(1);
    lap = 1'b0; lap_rd = 1'b0; step(1);
    check("empty_pp_cnt", lap_count, 1);
    check("empty_pp_head", disp, pk(0, 0, 0, 11));

    // Clear priority over tick and push
    run = 1'b1; step(3);
    zera = 1'b0; lap = 1'b1; step(1);
    lap = 1'b0;
    check("clr_cnt", lap_count, 0);
    check("clr_empty", lap_empty, 1);
    check("clr_done", done, 0);
    pulse_rc();
    pulse_rc();
    check("clr_view", view, 1);
    check("clr_sw", disp, 0);
    zera = 1'b1; run = 1'b0;

    // View FSM
    pulse_rc();
    pulse_rc();
    check("view_home", view, 0);
    view_exp[0] = 1; view_exp[1] = 2; view_exp[2] = 0; view_exp[3] = 1;
    for (int i = 0; i < 4; i++) begin
      pulse_rc();
      check($sformatf("view_seq%0d", i), view, view_exp[i]);
      check($sformatf("nrc_seq%0d", i), nrc, (view_exp[i] == 0) ? 1 : 0);
    end
    rc = 1'b1; step(20);
    check("rc_held", view, 2);
    rc = 1'b0; step(1);

    // Asynchronous reset mid-count
    run = 1'b1; lap = 1'b1; step(5);
    lap = 1'b0;
    #2 res = 1'b0;
    #1;
    check_reset_state("async_rst");
    res = 1'b1;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
